// File: rtl/fetch_stage_if.sv
// Bundle of memory, redirect and decode-side signals around the fetch stage.
// master = the fetch stage itself, slave = memory/redirect/decode environment.
interface fetch_stage_if #(
   parameter int ISSUE_W = 2
);
   logic [31:0]           imem_addr;
   logic [32*ISSUE_W-1:0] imem_rdata;
   logic                  imem_err;
   logic                  redirect_valid;
   logic [31:0]           redirect_pc;
   logic                  out_valid;
   logic                  out_ready;
   logic [31:0]           out_pc;
   logic [32*ISSUE_W-1:0] out_inst;
   logic                  out_err;
   logic                  halt;
   logic [31:0]           fetch_count;

   modport master (
      output imem_addr, out_valid, out_pc, out_inst, out_err, halt, fetch_count,
      input  imem_rdata, imem_err, redirect_valid, redirect_pc, out_ready
   );

   modport slave (
      input  imem_addr, out_valid, out_pc, out_inst, out_err, halt, fetch_count,
      output imem_rdata, imem_err, redirect_valid, redirect_pc, out_ready
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencer feeding a BUF_DEPTH-entry bundle queue,
// with redirect flush and a sticky halt on memory access errors.
module fetch_stage #(
   parameter int          ISSUE_W   = 2,
   parameter int          BUF_DEPTH = 4,
   parameter logic [31:0] RESET_PC  = 32'h0000_1000
) (
   input  logic          clk,
   input  logic          rst,
   fetch_stage_if.master bus
);
   localparam int          IW        = 32 * ISSUE_W;
   localparam int          PW        = $clog2(BUF_DEPTH);
   localparam int          OW        = PW + 1;
   localparam logic [31:0] STEP      = 32'(4 * ISSUE_W);
   localparam logic [31:0] ALIGN_MSK = ~(STEP - 32'd1);

   logic [31:0]   pc_q, pc_d;
   logic          halt_q, halt_d;
   logic [31:0]   cnt_q, cnt_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [OW-1:0] occ_q, occ_d;
   logic          enq, deq;

   logic [31:0]   pc_mem   [BUF_DEPTH];
   logic [IW-1:0] inst_mem [BUF_DEPTH];
   logic          err_mem  [BUF_DEPTH];

   // A redirect suppresses both handshakes, so the head it flushes is never consumed.
   always_comb begin
      deq = (occ_q != '0) && bus.out_ready && !bus.redirect_valid;
      enq = !halt_q && !bus.redirect_valid && ((occ_q != OW'(BUF_DEPTH)) || deq);
   end

   always_comb begin
      pc_d     = pc_q;
      halt_d   = halt_q;
      cnt_d    = cnt_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (bus.redirect_valid) begin
         pc_d     = bus.redirect_pc & ALIGN_MSK;
         halt_d   = 1'b0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         occ_d    = '0;
      end else begin
         if (enq) begin
            pc_d     = pc_q + STEP;
            cnt_d    = cnt_q + 32'd1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (bus.imem_err) begin
               halt_d = 1'b1;
            end
         end
         if (deq) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         if (enq && !deq) begin
            occ_d = occ_q + OW'(1);
         end else if (deq && !enq) begin
            occ_d = occ_q - OW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_q     <= RESET_PC;
         halt_q   <= 1'b0;
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         pc_q     <= pc_d;
         halt_q   <= halt_d;
         cnt_q    <= cnt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // Queue storage needs no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (rst && enq) begin
         pc_mem[wr_ptr_q]   <= pc_q;
         inst_mem[wr_ptr_q] <= bus.imem_rdata;
         err_mem[wr_ptr_q]  <= bus.imem_err;
      end
   end

   assign bus.imem_addr   = pc_q;
   assign bus.out_valid   = (occ_q != '0);
   assign bus.out_pc      = pc_mem[rd_ptr_q];
   assign bus.out_inst    = inst_mem[rd_ptr_q];
   assign bus.out_err     = bus.out_valid && err_mem[rd_ptr_q];
   assign bus.halt        = halt_q;
   assign bus.fetch_count = cnt_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic checked
// against a queue-based model of the fetch rules.
module tb_fetch_stage;
   localparam int          DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h0000_1000;

   typedef struct {
      logic [31:0] pc;
      logic [63:0] inst;
      logic        err;
   } ent_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        out_ready = 1'b0;
   logic        err_en = 1'b0;
   logic [31:0] err_addr = '0;

   logic        r2_rst = 1'b0;
   logic        r2_redir = 1'b0;
   logic [31:0] r2_pc = '0;
   logic        r2_ready = 1'b0;

   int n_checks = 0;
   int n_fail = 0;

   ent_t        m_q[$];
   logic [31:0] m_pc = RPC;
   logic        m_halt = 1'b0;
   logic [31:0] m_cnt = '0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], 16'h0} ^ a ^ 32'hC3A5_5A3C;
   endfunction

   function automatic logic [63:0] bundle2(input logic [31:0] a);
      return {mem_word(a + 32'd4), mem_word(a)};
   endfunction

   function automatic logic [127:0] bundle4(input logic [31:0] a);
      return {mem_word(a + 32'd12), mem_word(a + 32'd8), mem_word(a + 32'd4), mem_word(a)};
   endfunction

   fetch_stage_if #(.ISSUE_W(2)) bus1 ();
   fetch_stage_if #(.ISSUE_W(4)) bus2 ();

   fetch_stage #(.ISSUE_W(2), .BUF_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst), .bus(bus1)
   );
   fetch_stage #(.ISSUE_W(4), .BUF_DEPTH(2), .RESET_PC(RPC)) dut4 (
      .clk(clk), .rst(r2_rst), .bus(bus2)
   );

   assign bus1.redirect_valid = redirect_valid;
   assign bus1.redirect_pc    = redirect_pc;
   assign bus1.out_ready      = out_ready;
   assign bus1.imem_rdata     = bundle2(bus1.imem_addr);
   assign bus1.imem_err       = err_en && (bus1.imem_addr == err_addr);

   assign bus2.redirect_valid = r2_redir;
   assign bus2.redirect_pc    = r2_pc;
   assign bus2.out_ready      = r2_ready;
   assign bus2.imem_rdata     = bundle4(bus2.imem_addr);
   assign bus2.imem_err       = 1'b0;

   // Advances the model by one edge from the current inputs, then clocks the DUTs.
   task automatic run_cycle();
      ent_t e;
      bit   deq, enq;
      if (!rst) begin
         m_q.delete();
         m_pc = RPC;
         m_halt = 1'b0;
         m_cnt = '0;
      end else if (redirect_valid) begin
         m_q.delete();
         m_pc = {redirect_pc[31:3], 3'b000};
         m_halt = 1'b0;
      end else begin
         deq = (m_q.size() != 0) && out_ready;
         enq = !m_halt && ((m_q.size() < DEPTH) || deq);
         if (deq) void'(m_q.pop_front());
         if (enq) begin
            e.pc = m_pc;
            e.inst = bundle2(m_pc);
            e.err = err_en && (m_pc == err_addr);
            m_q.push_back(e);
            m_pc = m_pc + 32'd8;
            m_cnt = m_cnt + 32'd1;
            if (e.err) m_halt = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      run_cycle();
      run_cycle();
      n_checks++; if (bus1.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus1.out_valid); end
      n_checks++; if (bus1.imem_addr !== RPC) begin n_fail++; $display("FAIL reset_addr: got %h want %h", bus1.imem_addr, RPC); end
      n_checks++; if (bus1.out_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus1.out_err); end
      n_checks++; if (bus1.halt !== 1'b0) begin n_fail++; $display("FAIL reset_halt: got %b want 0", bus1.halt); end
      n_checks++; if (bus1.fetch_count !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus1.fetch_count); end
   endtask

   task automatic test_stream();
      logic [31:0] exp_pc;
      rst = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         run_cycle();
         exp_pc = RPC + 32'(8 * k);
         n_checks++; if (bus1.out_pc !== exp_pc) begin n_fail++; $display("FAIL stream_pc%0d: got %h want %h", k, bus1.out_pc, exp_pc); end
         n_checks++; if (bus1.out_inst !== bundle2(exp_pc)) begin n_fail++; $display("FAIL stream_inst%0d: got %h want %h", k, bus1.out_inst, bundle2(exp_pc)); end
      end
      n_checks++; if (bus1.fetch_count !== 32'd3) begin n_fail++; $display("FAIL stream_count: got %0d want 3", bus1.fetch_count); end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_pc;
      rst = 1'b0;
      run_cycle();
      rst = 1'b1;
      out_ready = 1'b0;
      for (int k = 0; k < 6; k++) run_cycle();
      n_checks++; if (bus1.imem_addr !== 32'h1020) begin n_fail++; $display("FAIL bp_hold_addr: got %h want 00001020", bus1.imem_addr); end
      n_checks++; if (bus1.fetch_count !== 32'd4) begin n_fail++; $display("FAIL bp_count: got %0d want 4", bus1.fetch_count); end
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         exp_pc = RPC + 32'(8 * k);
         n_checks++; if (bus1.out_pc !== exp_pc || bus1.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_drain%0d: got %h/%b want %h/1", k, bus1.out_pc, bus1.out_valid, exp_pc); end
         run_cycle();
      end
   endtask

   task automatic test_redirect();
      logic [31:0] cnt_before;
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) run_cycle();
      n_checks++; if (bus1.out_valid !== 1'b1) begin n_fail++; $display("FAIL redir_full: got %b want 1", bus1.out_valid); end
      cnt_before = m_cnt;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_2006;
      out_ready = 1'b1;
      run_cycle();
      redirect_valid = 1'b0;
      n_checks++; if (bus1.out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush: got %b want 0", bus1.out_valid); end
      n_checks++; if (bus1.imem_addr !== 32'h2000) begin n_fail++; $display("FAIL redir_addr: got %h want 00002000", bus1.imem_addr); end
      n_checks++; if (bus1.fetch_count !== cnt_before) begin n_fail++; $display("FAIL redir_count: got %0d want %0d", bus1.fetch_count, cnt_before); end
      run_cycle();
      n_checks++; if (bus1.out_pc !== 32'h2000 || bus1.out_valid !== 1'b1) begin n_fail++; $display("FAIL redir_resume: got %h/%b want 00002000/1", bus1.out_pc, bus1.out_valid); end
   endtask

   task automatic test_error();
      logic [31:0] exp_pc;
      rst = 1'b0;
      run_cycle();
      rst = 1'b1;
      out_ready = 1'b0;
      err_en = 1'b1;
      err_addr = 32'h1010;
      for (int k = 0; k < 5; k++) run_cycle();
      n_checks++; if (bus1.halt !== 1'b1) begin n_fail++; $display("FAIL err_halt: got %b want 1", bus1.halt); end
      n_checks++; if (bus1.fetch_count !== 32'd3) begin n_fail++; $display("FAIL err_count: got %0d want 3", bus1.fetch_count); end
      n_checks++; if (bus1.imem_addr !== 32'h1018) begin n_fail++; $display("FAIL err_addr: got %h want 00001018", bus1.imem_addr); end
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         exp_pc = RPC + 32'(8 * k);
         n_checks++; if (bus1.out_pc !== exp_pc || bus1.out_err !== (k == 2)) begin n_fail++; $display("FAIL err_drain%0d: got %h/%b want %h/%b", k, bus1.out_pc, bus1.out_err, exp_pc, (k == 2)); end
         run_cycle();
      end
      n_checks++; if (bus1.out_valid !== 1'b0 || bus1.fetch_count !== 32'd3) begin n_fail++; $display("FAIL err_no_more: got %b/%0d want 0/3", bus1.out_valid, bus1.fetch_count); end
      err_en = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = 32'h1000;
      run_cycle();
      redirect_valid = 1'b0;
      n_checks++; if (bus1.halt !== 1'b0 || bus1.imem_addr !== 32'h1000) begin n_fail++; $display("FAIL err_clear: got %b/%h want 0/00001000", bus1.halt, bus1.imem_addr); end
   endtask

   task automatic test_midreset();
      rst = 1'b0;
      run_cycle();
      rst = 1'b1;
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) run_cycle();
      n_checks++; if (bus1.fetch_count !== 32'd3) begin n_fail++; $display("FAIL mrst_fill: got %0d want 3", bus1.fetch_count); end
      rst = 1'b0;
      run_cycle();
      n_checks++; if (bus1.out_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_valid: got %b want 0", bus1.out_valid); end
      n_checks++; if (bus1.imem_addr !== RPC) begin n_fail++; $display("FAIL mrst_addr: got %h want %h", bus1.imem_addr, RPC); end
      n_checks++; if (bus1.fetch_count !== 32'd0) begin n_fail++; $display("FAIL mrst_count: got %0d want 0", bus1.fetch_count); end
      rst = 1'b1;
   endtask

   task automatic test_wrap();
      r2_rst = 1'b1;
      r2_ready = 1'b1;
      r2_redir = 1'b1;
      r2_pc = 32'hFFFF_FFFC;
      run_cycle();
      r2_redir = 1'b0;
      n_checks++; if (bus2.imem_addr !== 32'hFFFF_FFF0 || bus2.out_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_align: got %h/%b want fffffff0/0", bus2.imem_addr, bus2.out_valid); end
      run_cycle();
      n_checks++; if (bus2.out_pc !== 32'hFFFF_FFF0 || bus2.imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_first: got %h/%h want fffffff0/00000000", bus2.out_pc, bus2.imem_addr); end
      n_checks++; if (bus2.out_inst !== bundle4(32'hFFFF_FFF0)) begin n_fail++; $display("FAIL wrap_inst: got %h want %h", bus2.out_inst, bundle4(32'hFFFF_FFF0)); end
      run_cycle();
      n_checks++; if (bus2.out_pc !== 32'h0 || bus2.imem_addr !== 32'h10) begin n_fail++; $display("FAIL wrap_next: got %h/%h want 00000000/00000010", bus2.out_pc, bus2.imem_addr); end
      r2_rst = 1'b0;
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 59) != 0);
         redirect_valid = ($urandom_range(0, 19) == 0);
         redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31))) : $urandom;
         out_ready = ($urandom_range(0, 2) != 0);
         err_en = ($urandom_range(0, 24) == 0);
         err_addr = m_pc;
         run_cycle();
         n_checks++; if (bus1.out_valid !== (m_q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid c%0d: got %b want %b", c, bus1.out_valid, (m_q.size() != 0)); end
         n_checks++; if (bus1.imem_addr !== m_pc) begin n_fail++; $display("FAIL rnd_addr c%0d: got %h want %h", c, bus1.imem_addr, m_pc); end
         n_checks++; if (bus1.halt !== m_halt) begin n_fail++; $display("FAIL rnd_halt c%0d: got %b want %b", c, bus1.halt, m_halt); end
         n_checks++; if (bus1.fetch_count !== m_cnt) begin n_fail++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, bus1.fetch_count, m_cnt); end
         if (m_q.size() != 0) begin
            n_checks++; if (bus1.out_pc !== m_q[0].pc) begin n_fail++; $display("FAIL rnd_pc c%0d: got %h want %h", c, bus1.out_pc, m_q[0].pc); end
            n_checks++; if (bus1.out_inst !== m_q[0].inst) begin n_fail++; $display("FAIL rnd_inst c%0d: got %h want %h", c, bus1.out_inst, m_q[0].inst); end
            n_checks++; if (bus1.out_err !== m_q[0].err) begin n_fail++; $display("FAIL rnd_err c%0d: got %b want %b", c, bus1.out_err, m_q[0].err); end
         end
      end
      rst = 1'b1;
      redirect_valid = 1'b0;
      err_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_error();
      test_midreset();
      test_wrap();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter ISSUE_W, default 2: instructions per fetch bundle; legal values 1, 2, 4.
REQ-002 Parameter BUF_DEPTH, default 4: fetch-queue entries; power of two, at least 2.
REQ-003 Parameter RESET_PC, default 32'h0000_1000: first fetch address after reset.
REQ-004 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-low.
REQ-006 Port imem_addr, output, 32: fetch address; SHALL always equal the PC register.
REQ-007 Port imem_rdata, input, 32*ISSUE_W: combinational read data; word i SHALL sit at bits [32i+31:32i] for address imem_addr+4i.
REQ-008 Port imem_err, input, 1: combinational access error for the current imem_addr.
REQ-009 Port redirect_valid, input, 1: branch/jump redirect request.
REQ-010 Port redirect_pc, input, 32: redirect target address.
REQ-011 Port out_valid, output, 1: the head bundle is valid.
REQ-012 Port out_ready, input, 1: downstream accepts the head bundle.
REQ-013 Port out_pc, output, 32: PC of the head bundle.
REQ-014 Port out_inst, output, 32*ISSUE_W: instructions of the head bundle.
REQ-015 Port out_err, output, 1: the head bundle was fetched with imem_err set.
REQ-016 Port halt, output, 1: sticky flag; fetch is stopped after an error.
REQ-017 Port fetch_count, output, 32: number of bundles enqueued since reset.

Function
REQ-018 Step size: STEP = 4*ISSUE_W bytes.
REQ-019 PC arithmetic: modulo 2^32; 32'hFFFF_FFF8+8 SHALL wrap to 0.
REQ-020 Queue: FIFO of {pc, inst, err} with BUF_DEPTH entries; read/write pointers wrap modulo BUF_DEPTH; occupancy range 0..BUF_DEPTH.
REQ-021 out_valid SHALL be 1 exactly when occupancy is nonzero.
REQ-022 out_pc, out_inst and out_err SHALL be driven combinationally from the head entry.
REQ-023 Dequeue SHALL occur when out_valid && out_ready.
REQ-024 Enqueue SHALL occur when !halt && !redirect_valid && (occupancy < BUF_DEPTH || dequeue this cycle).
REQ-025 An enqueue SHALL write {pc, imem_rdata, imem_err} and advance pc by STEP.
REQ-026 Enqueue and dequeue in the same cycle SHALL leave occupancy unchanged, including when the queue is full.
REQ-027 When the queue is full and there is no dequeue, pc SHALL hold and no entry is overwritten.
REQ-028 Enqueue latency: an entry written at edge N SHALL be visible at out_* after edge N, in the same cycle.
REQ-029 An enqueue with imem_err=1 SHALL set halt in the same edge; while halt=1 no further enqueues occur, and draining continues normally.
REQ-030 Redirect takes priority over enqueue and dequeue; when redirect_valid=1, the next edge SHALL:
 - flush the queue (occupancy 0);
 - load pc with {redirect_pc[31:2+log2(ISSUE_W)], zeros}, i.e. aligned down to STEP;
 - clear halt;
 - leave fetch_count unchanged.
REQ-031 A redirect that coincides with out_ready=1 SHALL NOT count as a handshake; the head is discarded.
REQ-032 Fetching SHALL resume from the new pc on the cycle after the redirect.
REQ-033 fetch_count SHALL increment by 1 per enqueue and wrap modulo 2^32.

Reset
REQ-034 While rst=0 at a rising edge, the following SHALL take effect on that edge regardless of all other inputs:
 - pc=RESET_PC;
 - occupancy=0, both pointers=0;
 - halt=0;
 - fetch_count=0.
REQ-035 Consequently, after reset: out_valid=0, imem_addr=RESET_PC, out_err=0.
REQ-036 Reset asserted mid-operation SHALL discard all queued entries.
REQ-037 The first enqueue SHALL occur on the first edge with rst=1.

Verification
REQ-038 Defaults, rst released, out_ready=1, error-free memory -> out_pc sequence 0x1000, 0x1008, 0x1010...; fetch_count=3 after 3 edges.
REQ-039 out_ready=0 for 6 cycles -> occupancy saturates at 4; imem_addr holds at 0x1020; after out_ready=1, bundles 0x1000..0x1018 drain in order with none lost.
REQ-040 Full queue, then redirect_valid=1 with redirect_pc=0x2006 and out_ready=1 -> next cycle out_valid=0, imem_addr=0x2000; fetch_count unchanged.
REQ-041 imem_err=1 at 0x1010 -> that entry has out_err=1 and halt=1; no entry 0x1018 is produced; a redirect to 0x1000 clears halt.
REQ-042 ISSUE_W=4, redirect to 0xFFFF_FFF0 -> next bundle pc is 0x0000_0000 (wrap).
REQ-043 rst=0 for one edge while the queue holds 3 entries -> out_valid=0, imem_addr=0x1000, fetch_count=0.
